// File: rtl/onchip_arb_pkg.sv
// Shared types and defaults for the two-master on-chip memory arbiter.
// Grant policy is selected by ONCHIP_ARB_RR_EN (see onchip_arb_grant).
package onchip_arb_pkg;

  localparam int unsigned ARB_ADDR_W_DEF = 12;
  localparam int unsigned ARB_DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

  localparam master_idx_t MASTER_0 = 1'b0;
  localparam master_idx_t MASTER_1 = 1'b1;

endpackage

// File: rtl/onchip_arb_grant.sv
// Combinational grant selection between two masters.
// ONCHIP_ARB_RR_EN defined: round-robin on the last-grant pointer; undefined: master 0 fixed priority.
module onchip_arb_grant
  import onchip_arb_pkg::*;
(
  input  logic        req0_i,
  input  logic        req1_i,
`ifdef ONCHIP_ARB_RR_EN
  input  master_idx_t last_i,
`endif
  output master_idx_t gnt_o,
  output logic        gnt_valid_o
);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
`ifdef ONCHIP_ARB_RR_EN
    if (req0_i && req1_i) begin
      gnt_o = (last_i == MASTER_0) ? MASTER_1 : MASTER_0;
    end else if (req1_i) begin
      gnt_o = MASTER_1;
    end else begin
      gnt_o = MASTER_0;
    end
`else
    if (req0_i) begin
      gnt_o = MASTER_0;
    end else if (req1_i) begin
      gnt_o = MASTER_1;
    end else begin
      gnt_o = MASTER_0;
    end
`endif
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM (IDLE -> ISSUE -> RDATA).
// Grant policy: ONCHIP_ARB_RR_EN defined = round-robin, undefined = master 0 fixed priority.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W_DEF,
  parameter int unsigned DATA_W = ARB_DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  // Reset asserts asynchronously but releases two edges after reset_n rises.
  logic [1:0] sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = sync_q[1];
  assign mem_clken = reset_n;

  arb_state_e        state_q, state_d;
  master_idx_t       grant_q, grant_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        wait_q, wait_d;
  logic              rdv0_q, rdv0_d;
  logic              rdv1_q, rdv1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [BE_W-1:0]   mbe_q, mbe_d;
  logic [DATA_W-1:0] mwd_q, mwd_d;
  logic              mcs_q, mcs_d;
  logic              mwr_q, mwr_d;

  master_idx_t gnt_idx;
  logic        gnt_any;

`ifdef ONCHIP_ARB_RR_EN
  master_idx_t last_q, last_d;

  onchip_arb_grant u_grant (
    .req0_i      (m0_read | m0_write),
    .req1_i      (m1_read | m1_write),
    .last_i      (last_q),
    .gnt_o       (gnt_idx),
    .gnt_valid_o (gnt_any)
  );
`else
  onchip_arb_grant u_grant (
    .req0_i      (m0_read | m0_write),
    .req1_i      (m1_read | m1_write),
    .gnt_o       (gnt_idx),
    .gnt_valid_o (gnt_any)
  );
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    is_wr_d  = is_wr_q;
    wait_d   = '1;
    rdv0_d   = 1'b0;
    rdv1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    maddr_d  = maddr_q;
    mbe_d    = mbe_q;
    mwd_d    = mwd_q;
    mcs_d    = 1'b0;
    mwr_d    = 1'b0;
`ifdef ONCHIP_ARB_RR_EN
    last_d   = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          // ISSUE-cycle outputs are registered here so they appear exactly in ISSUE.
          grant_d = gnt_idx;
          if (gnt_idx == MASTER_1) begin
            is_wr_d = m1_write;
            maddr_d = m1_address;
            mbe_d   = m1_byteenable;
            mwd_d   = m1_writedata;
            mwr_d   = m1_write;
          end else begin
            is_wr_d = m0_write;
            maddr_d = m0_address;
            mbe_d   = m0_byteenable;
            mwd_d   = m0_writedata;
            mwr_d   = m0_write;
          end
          mcs_d           = 1'b1;
          wait_d[gnt_idx] = 1'b0;
`ifdef ONCHIP_ARB_RR_EN
          last_d          = gnt_idx;
`endif
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = is_wr_q ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        if (grant_q == MASTER_1) begin
          rdata1_d = mem_readdata;
          rdv1_d   = 1'b1;
        end else begin
          rdata0_d = mem_readdata;
          rdv0_d   = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= MASTER_0;
      is_wr_q  <= 1'b0;
      wait_q   <= '1;
      rdv0_q   <= 1'b0;
      rdv1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      maddr_q  <= '0;
      mbe_q    <= '0;
      mwd_q    <= '0;
      mcs_q    <= 1'b0;
      mwr_q    <= 1'b0;
`ifdef ONCHIP_ARB_RR_EN
      last_q   <= MASTER_1;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      is_wr_q  <= is_wr_d;
      wait_q   <= wait_d;
      rdv0_q   <= rdv0_d;
      rdv1_q   <= rdv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      maddr_q  <= maddr_d;
      mbe_q    <= mbe_d;
      mwd_q    <= mwd_d;
      mcs_q    <= mcs_d;
      mwr_q    <= mwr_d;
`ifdef ONCHIP_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign m0_waitrequest   = wait_q[0];
  assign m1_waitrequest   = wait_q[1];
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign m0_readdata      = rdata0_q;
  assign m1_readdata      = rdata1_q;
  assign mem_address      = maddr_q;
  assign mem_byteenable   = mbe_q;
  assign mem_writedata    = mwd_q;
  assign mem_chipselect   = mcs_q;
  assign mem_write        = mwr_q;

endmodule
